// File: rtl/debug_mon_access.sv
// debug_mon_access: system-clock engine that turns decoded JTAG debug
// commands into single-word read/write transactions on a waitrequest-style
// port to the debug monitor RAM. It reports read data, readiness and a
// sticky error flag back to the debug slave.

module debug_mon_access #(
    parameter int ADDR_WIDTH = 8,
    parameter int TIMEOUT    = 255
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [37:0]           jdo,
    input  logic                  take_action_ocimem_a,
    input  logic                  take_action_ocimem_b,
    input  logic                  take_no_action_ocimem_a,
    output logic [31:0]           MonDReg,
    output logic                  monitor_ready,
    output logic                  monitor_error,
    output logic [ADDR_WIDTH-1:0] mem_address,
    output logic                  mem_read,
    output logic                  mem_write,
    output logic [31:0]           mem_writedata,
    input  logic [31:0]           mem_readdata,
    input  logic                  mem_waitrequest
);

    localparam int CNT_W = 16;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WR      = 2'd1,
        RD      = 2'd2,
        RD_WAIT = 2'd3
    } state_t;

    state_t state;
    state_t next_state;

    logic [CNT_W-1:0] wait_cnt;
    logic             is_idle;
    logic             cmd_a;
    logic             cmd_b;
    logic             cmd_na;
    logic             dropped;
    logic             stall;
    logic             timeout_hit;
    logic             unused_bits;

    // The top two bits and the low three bits of jdo carry nothing this
    // engine uses; the address field may also be narrower than 8 bits.
    assign unused_bits = ^{jdo[37:36], jdo[33:26], jdo[2:0]};

    // Command priority is a > b > no_action; anything that loses the
    // arbitration, or arrives while busy, is dropped and flagged.
    always_comb begin
        is_idle = (state == IDLE);
        cmd_a   = take_action_ocimem_a;
        cmd_b   = take_action_ocimem_b & ~take_action_ocimem_a;
        cmd_na  = take_no_action_ocimem_a & ~take_action_ocimem_a
                  & ~take_action_ocimem_b;
        if (is_idle) begin
            dropped = (take_action_ocimem_a & (take_action_ocimem_b | take_no_action_ocimem_a))
                    | (take_action_ocimem_b & take_no_action_ocimem_a);
        end else begin
            dropped = take_action_ocimem_a | take_action_ocimem_b | take_no_action_ocimem_a;
        end
        stall       = ((state == WR) || (state == RD)) && mem_waitrequest;
        timeout_hit = stall && (wait_cnt == CNT_W'(TIMEOUT - 1));
    end

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic: a stalled request either completes or is aborted
    // once it has spent TIMEOUT consecutive cycles waiting.
    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (cmd_a) begin
                    if (jdo[34]) begin
                        next_state = RD;
                    end
                end else if (cmd_b) begin
                    next_state = WR;
                end else if (cmd_na) begin
                    next_state = RD;
                end
            end
            WR: begin
                if (timeout_hit || !mem_waitrequest) begin
                    next_state = IDLE;
                end
            end
            RD: begin
                if (timeout_hit) begin
                    next_state = IDLE;
                end else if (!mem_waitrequest) begin
                    next_state = RD_WAIT;
                end
            end
            RD_WAIT: begin
                next_state = IDLE;
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // Outputs decoded from the state register, so they are glitch-free and
    // the strobes hold steady for as long as the RAM stalls.
    always_comb begin
        mem_write     = (state == WR);
        mem_read      = (state == RD);
        monitor_ready = (state == IDLE);
    end

    // Stall counter: restarts on every state change, counts waitrequest cycles.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wait_cnt <= '0;
        end else if (next_state != state) begin
            wait_cnt <= '0;
        end else if (stall) begin
            wait_cnt <= wait_cnt + CNT_W'(1);
        end
    end

    // Address pointer: loaded by ocimem_a, advanced after each completed
    // access, wrapping naturally at the top of the address space.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mem_address <= '0;
        end else if (is_idle && cmd_a) begin
            mem_address <= jdo[26 +: ADDR_WIDTH];
        end else if (((state == WR) && !mem_waitrequest) || (state == RD_WAIT)) begin
            mem_address <= mem_address + ADDR_WIDTH'(1);
        end
    end

    // Write data is captured only when a write is accepted from IDLE.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mem_writedata <= '0;
        end else if (is_idle && cmd_b) begin
            mem_writedata <= jdo[34:3];
        end
    end

    // Read data is taken in the cycle after the RAM accepted the read.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            MonDReg <= '0;
        end else if (state == RD_WAIT) begin
            MonDReg <= mem_readdata;
        end
    end

    // Sticky error: setting wins over a clear arriving in the same cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            monitor_error <= 1'b0;
        end else if (dropped || timeout_hit) begin
            monitor_error <= 1'b1;
        end else if (is_idle && cmd_a && jdo[35]) begin
            monitor_error <= 1'b0;
        end
    end

endmodule

// File: tb/tb_debug_mon_access.sv
// tb_debug_mon_access: directed, table-driven bench for debug_mon_access.
// Each table row is one clock of inputs plus the outputs expected just
// after that clock edge; reset behaviour is exercised by hand afterwards.

module tb_debug_mon_access;

    logic        clk;
    logic        reset;
    logic [37:0] jdo;
    logic        take_action_ocimem_a;
    logic        take_action_ocimem_b;
    logic        take_no_action_ocimem_a;
    logic [31:0] MonDReg;
    logic        monitor_ready;
    logic        monitor_error;
    logic [7:0]  mem_address;
    logic        mem_read;
    logic        mem_write;
    logic [31:0] mem_writedata;
    logic [31:0] mem_readdata;
    logic        mem_waitrequest;

    int n_vec;
    int n_bad;

    typedef struct {
        logic        a;
        logic        b;
        logic        na;
        logic [37:0] jdo;
        logic        wait_req;
        logic [31:0] rdata;
        logic        e_ready;
        logic        e_read;
        logic        e_write;
        logic [7:0]  e_addr;
        logic [31:0] e_wdata;
        logic        e_err;
        logic [31:0] e_mon;
    } vec_t;

    vec_t vecs[$];

    debug_mon_access #(
        .ADDR_WIDTH(8),
        .TIMEOUT   (4)
    ) dut (
        .clk                    (clk),
        .reset                  (reset),
        .jdo                    (jdo),
        .take_action_ocimem_a   (take_action_ocimem_a),
        .take_action_ocimem_b   (take_action_ocimem_b),
        .take_no_action_ocimem_a(take_no_action_ocimem_a),
        .MonDReg                (MonDReg),
        .monitor_ready          (monitor_ready),
        .monitor_error          (monitor_error),
        .mem_address            (mem_address),
        .mem_read               (mem_read),
        .mem_write              (mem_write),
        .mem_writedata          (mem_writedata),
        .mem_readdata           (mem_readdata),
        .mem_waitrequest        (mem_waitrequest)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [37:0] jdo_a(input logic clr, input logic rd, input logic [7:0] addr);
        return {2'b00, clr, rd, addr, 26'd0};
    endfunction

    function automatic logic [37:0] jdo_b(input logic [31:0] data);
        return {3'b000, data, 3'b000};
    endfunction

    task automatic add(input logic a, input logic b, input logic na, input logic [37:0] j,
                       input logic w, input logic [31:0] rd,
                       input logic er, input logic erd, input logic ewr, input logic [7:0] ead,
                       input logic [31:0] ewd, input logic eer, input logic [31:0] emon);
        vec_t v;
        v.a = a; v.b = b; v.na = na; v.jdo = j; v.wait_req = w; v.rdata = rd;
        v.e_ready = er; v.e_read = erd; v.e_write = ewr; v.e_addr = ead;
        v.e_wdata = ewd; v.e_err = eer; v.e_mon = emon;
        vecs.push_back(v);
    endtask

    task automatic apply_stimulus(input vec_t v);
        @(negedge clk);
        take_action_ocimem_a    = v.a;
        take_action_ocimem_b    = v.b;
        take_no_action_ocimem_a = v.na;
        jdo                     = v.jdo;
        mem_waitrequest         = v.wait_req;
        mem_readdata            = v.rdata;
        @(posedge clk);
        #1;
    endtask

    task automatic check_output(input string name, input logic er, input logic erd,
                                input logic ewr, input logic [7:0] ead, input logic [31:0] ewd,
                                input logic eer, input logic [31:0] emon);
        n_vec++;
        if (monitor_ready !== er) begin
            n_bad++;
            $display("[TB] FAIL %s monitor_ready got %0b want %0b", name, monitor_ready, er);
        end
        if (mem_read !== erd) begin
            n_bad++;
            $display("[TB] FAIL %s mem_read got %0b want %0b", name, mem_read, erd);
        end
        if (mem_write !== ewr) begin
            n_bad++;
            $display("[TB] FAIL %s mem_write got %0b want %0b", name, mem_write, ewr);
        end
        if (mem_address !== ead) begin
            n_bad++;
            $display("[TB] FAIL %s mem_address got %h want %h", name, mem_address, ead);
        end
        if (mem_writedata !== ewd) begin
            n_bad++;
            $display("[TB] FAIL %s mem_writedata got %h want %h", name, mem_writedata, ewd);
        end
        if (monitor_error !== eer) begin
            n_bad++;
            $display("[TB] FAIL %s monitor_error got %0b want %0b", name, monitor_error, eer);
        end
        if (MonDReg !== emon) begin
            n_bad++;
            $display("[TB] FAIL %s MonDReg got %h want %h", name, MonDReg, emon);
        end
    endtask

    initial begin
        n_vec = 0;
        n_bad = 0;
        reset = 1'b1;
        jdo = '0;
        take_action_ocimem_a = 1'b0;
        take_action_ocimem_b = 1'b0;
        take_no_action_ocimem_a = 1'b0;
        mem_readdata = '0;
        mem_waitrequest = 1'b0;

        // Load 0x10, zero-wait write of DEADBEEF.
        add(1,0,0, jdo_a(0,0,8'h10), 0, 0,            1,0,0, 8'h10, 32'h0,        0, 32'h0);
        add(0,1,0, jdo_b(32'hDEADBEEF), 0, 0,         0,0,1, 8'h10, 32'hDEADBEEF, 0, 32'h0);
        add(0,0,0, '0, 0, 0,                          1,0,0, 8'h11, 32'hDEADBEEF, 0, 32'h0);
        // Load-and-read at 0x10 with three stall cycles.
        add(1,0,0, jdo_a(0,1,8'h10), 0, 0,            0,1,0, 8'h10, 32'hDEADBEEF, 0, 32'h0);
        add(0,0,0, '0, 1, 0,                          0,1,0, 8'h10, 32'hDEADBEEF, 0, 32'h0);
        add(0,0,0, '0, 1, 0,                          0,1,0, 8'h10, 32'hDEADBEEF, 0, 32'h0);
        add(0,0,0, '0, 1, 0,                          0,1,0, 8'h10, 32'hDEADBEEF, 0, 32'h0);
        add(0,0,0, '0, 0, 0,                          0,0,0, 8'h10, 32'hDEADBEEF, 0, 32'h0);
        add(0,0,0, '0, 0, 32'hCAFEF00D,               1,0,0, 8'h11, 32'hDEADBEEF, 0, 32'hCAFEF00D);
        // Address wrap: load 0xFF, two no_action reads.
        add(1,0,0, jdo_a(0,0,8'hFF), 0, 0,            1,0,0, 8'hFF, 32'hDEADBEEF, 0, 32'hCAFEF00D);
        add(0,0,1, '0, 0, 0,                          0,1,0, 8'hFF, 32'hDEADBEEF, 0, 32'hCAFEF00D);
        add(0,0,0, '0, 0, 0,                          0,0,0, 8'hFF, 32'hDEADBEEF, 0, 32'hCAFEF00D);
        add(0,0,0, '0, 0, 32'h11111111,               1,0,0, 8'h00, 32'hDEADBEEF, 0, 32'h11111111);
        add(0,0,1, '0, 0, 0,                          0,1,0, 8'h00, 32'hDEADBEEF, 0, 32'h11111111);
        add(0,0,0, '0, 0, 0,                          0,0,0, 8'h00, 32'hDEADBEEF, 0, 32'h11111111);
        add(0,0,0, '0, 0, 32'h22222222,               1,0,0, 8'h01, 32'hDEADBEEF, 0, 32'h22222222);
        // no_action during a stalled write is dropped and flagged.
        add(0,1,0, jdo_b(32'h12345678), 0, 0,         0,0,1, 8'h01, 32'h12345678, 0, 32'h22222222);
        add(0,0,1, '0, 1, 0,                          0,0,1, 8'h01, 32'h12345678, 1, 32'h22222222);
        add(0,0,0, '0, 0, 0,                          1,0,0, 8'h02, 32'h12345678, 1, 32'h22222222);
        add(0,0,0, '0, 0, 0,                          1,0,0, 8'h02, 32'h12345678, 1, 32'h22222222);
        add(1,0,0, jdo_a(1,0,8'h02), 0, 0,            1,0,0, 8'h02, 32'h12345678, 0, 32'h22222222);
        // Write held off by waitrequest until the 4-cycle timeout fires.
        add(0,1,0, jdo_b(32'h0BADF00D), 0, 0,         0,0,1, 8'h02, 32'h0BADF00D, 0, 32'h22222222);
        add(0,0,0, '0, 1, 0,                          0,0,1, 8'h02, 32'h0BADF00D, 0, 32'h22222222);
        add(0,0,0, '0, 1, 0,                          0,0,1, 8'h02, 32'h0BADF00D, 0, 32'h22222222);
        add(0,0,0, '0, 1, 0,                          0,0,1, 8'h02, 32'h0BADF00D, 0, 32'h22222222);
        add(0,0,0, '0, 1, 0,                          1,0,0, 8'h02, 32'h0BADF00D, 1, 32'h22222222);
        // a with clear plus b together: a wins, set beats clear.
        add(1,1,0, jdo_a(1,0,8'h20), 0, 0,            1,0,0, 8'h20, 32'h0BADF00D, 1, 32'h22222222);
        add(1,0,0, jdo_a(1,0,8'h02), 0, 0,            1,0,0, 8'h02, 32'h0BADF00D, 0, 32'h22222222);
        // b and no_action together: write wins, no read, error set.
        add(0,1,1, jdo_b(32'hA5A5A5A5), 0, 0,         0,0,1, 8'h02, 32'hA5A5A5A5, 1, 32'h22222222);
        add(0,0,0, '0, 1, 0,                          0,0,1, 8'h02, 32'hA5A5A5A5, 1, 32'h22222222);

        repeat (2) @(posedge clk);
        #1;
        check_output("reset_hold", 1, 0, 0, 8'h00, 32'h0, 0, 32'h0);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        check_output("after_reset", 1, 0, 0, 8'h00, 32'h0, 0, 32'h0);

        for (int i = 0; i < vecs.size(); i++) begin
            apply_stimulus(vecs[i]);
            check_output($sformatf("vec%0d", i), vecs[i].e_ready, vecs[i].e_read,
                         vecs[i].e_write, vecs[i].e_addr, vecs[i].e_wdata,
                         vecs[i].e_err, vecs[i].e_mon);
        end

        // Reset in the middle of the stalled write aborts it at once.
        #3;
        reset = 1'b1;
        #1;
        check_output("reset_mid_write", 1, 0, 0, 8'h00, 32'h0, 0, 32'h0);
        @(negedge clk);
        reset = 1'b0;
        mem_waitrequest = 1'b0;
        @(posedge clk);
        #1;
        check_output("post_abort_idle", 1, 0, 0, 8'h00, 32'h0, 0, 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
